demux_1an_rr: RTL and testbench

- Parametrised successor of the fixed 8-bit 1-to-2 valid demux in the byte-striping path.
- Steers a single valid-qualified input word stream onto N_LANES registered output lanes, clocked by clk_4f.
- Two steering modes: round-robin (striping) and explicit lane select.
- Adds lane-pointer restart, frame-complete pulse and select-error flagging, which the 1-to-2 version lacks.
- Sits between the serial-to-parallel stage and the per-lane processing in the receive path.

---
 rtl/demux_1an_rr.sv | 105 ++++++++++
 tb/tb_demux_1an_rr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1an_rr.sv
// Purpose : steer one valid-qualified word stream onto N_LANES registered lanes (round-robin or explicit select).
// Latency : 1 cycle, every output is registered; no combinational input-to-output path.
// Backpr. : none; every valid word is taken each cycle (out-of-range selects are dropped and flagged).
//
// Ports:
//   clk_4f     - single clock, rising edge
//   reset      - synchronous active-high reset; overrides valid/restart
//   valid      - data_in carries a word this cycle
//   data_in    - input word (DATA_W bits)
//   restart    - MODE 0: steer this word (if any) to lane 0 and restart the pointer
//   lane_sel   - MODE 1: target lane, SEL_W = max(1, clog2(N_LANES))
//   validout   - one-hot pulse, bit k = lane k written in the previous cycle
//   dataout    - lane k at [k*DATA_W +: DATA_W]
//   frame_done - lane N_LANES-1 written in the previous cycle
//   err_sel    - MODE 1 word dropped because lane_sel >= N_LANES
//
// Optional macro DEMUX_IDLE_FILL_EN: unwritten lanes drive IDLE_WORD instead of
// holding their last value. Flags and validout are unaffected by the macro.
module demux_1an_rr #(
    parameter int                 DATA_W    = 8,
    parameter int                 N_LANES   = 2,
    parameter int                 MODE      = 0,
    parameter logic [DATA_W-1:0]  IDLE_WORD = 'hBC,
    localparam int                SEL_W     = (N_LANES > 2) ? $clog2(N_LANES) : 1
) (
    input  logic                        clk_4f,
    input  logic                        reset,
    input  logic                        valid,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        restart,
    input  logic [SEL_W-1:0]            lane_sel,
    output logic [N_LANES-1:0]          validout,
    output logic [N_LANES*DATA_W-1:0]   dataout,
    output logic                        frame_done,
    output logic                        err_sel
);

    localparam logic             SEL_MODE  = (MODE == 1);
    localparam logic [SEL_W-1:0] LAST      = SEL_W'(N_LANES - 1);
    // one extra bit so N_LANES itself is representable for the range check
    localparam logic [SEL_W:0]   LANES_CMP = (SEL_W + 1)'(N_LANES);

`ifdef DEMUX_IDLE_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif

    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   tgt;
    logic               wr_en;
    logic               drop;
    logic [N_LANES-1:0] lane_hit;

    always_comb begin
        tgt      = '0;
        wr_en    = 1'b0;
        drop     = 1'b0;
        lane_hit = '0;
        if (SEL_MODE) begin
            tgt   = lane_sel;
            wr_en = valid && ({1'b0, lane_sel} < LANES_CMP);
            drop  = valid && !wr_en;
        end else begin
            tgt   = restart ? '0 : ptr;
            wr_en = valid;
        end
        if (wr_en) begin
            lane_hit = {{(N_LANES-1){1'b0}}, 1'b1} << tgt;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            ptr        <= '0;
            validout   <= '0;
            dataout    <= '0;
            frame_done <= 1'b0;
            err_sel    <= 1'b0;
        end else begin
            validout   <= lane_hit;
            frame_done <= lane_hit[N_LANES-1];
            err_sel    <= drop;

            for (int k = 0; k < N_LANES; k++) begin
                if (lane_hit[k]) begin
                    dataout[k*DATA_W +: DATA_W] <= data_in;
                end else if (FILL_EN) begin
                    dataout[k*DATA_W +: DATA_W] <= IDLE_WORD;
                end
            end

            // Pointer only moves in round-robin mode; in select mode it stays at 0.
            // Explicit compare against LAST keeps non-power-of-2 lane counts in range.
            if (!SEL_MODE) begin
                if (restart) begin
                    ptr <= valid ? SEL_W'(1) : '0;
                end else if (valid) begin
                    ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1an_rr.sv
// Purpose : checks several demux_1an_rr configurations against a lane-array model.
// Latency : model outputs correspond to the previous rising edge, compared at the falling edge.
// Backpr. : n/a (stimulus-only bench).
module tb_demux_1an_rr;

    localparam int NI = 5;
    localparam int NL [NI] = '{2, 3, 4, 3, 5};
    localparam int MD [NI] = '{0, 0, 0, 1, 1};

    logic       clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    logic       reset   = 1'b1;
    logic       valid   = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] sel     = '0;

    logic [NI*8-1:0]  vo_all;
    logic [NI*64-1:0] do_all;
    logic [NI-1:0]    fd_all;
    logic [NI-1:0]    er_all;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N  = NL[g];
        localparam int SW = (N > 2) ? $clog2(N) : 1;
        logic [N-1:0]   v;
        logic [N*8-1:0] d;
        demux_1an_rr #(.DATA_W(8), .N_LANES(N), .MODE(MD[g]), .IDLE_WORD(8'hBC)) u_dut (
            .clk_4f     (clk_4f),
            .reset      (reset),
            .valid      (valid),
            .data_in    (data_in),
            .restart    (restart),
            .lane_sel   (sel[SW-1:0]),
            .validout   (v),
            .dataout    (d),
            .frame_done (fd_all[g]),
            .err_sel    (er_all[g])
        );
        assign vo_all[g*8 +: 8]   = 8'(v);
        assign do_all[g*64 +: 64] = 64'(d);
    end

    int n_vec = 0;
    int n_bad = 0;
    int n_cmp = 0;

    // behavioural model: pointer as an integer, lanes as a byte array
    int         m_ptr  [NI];
    logic [7:0] m_lane [NI][8];
    logic [7:0] m_vo   [NI];
    logic       m_fd   [NI];
    logic       m_er   [NI];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_of(input int i, input int k);
        return do_all[i*64 + k*8 +: 8];
    endfunction

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            int tgt;
            int sw;
            int sv;
            logic err;
            if (reset) begin
                m_ptr[i] = 0;
                m_vo[i]  = '0;
                m_fd[i]  = 1'b0;
                m_er[i]  = 1'b0;
                for (int k = 0; k < 8; k++) m_lane[i][k] = '0;
            end else begin
                tgt = -1;
                err = 1'b0;
                sw  = (NL[i] > 2) ? $clog2(NL[i]) : 1;
                sv  = int'(sel) % (1 << sw);
                if (valid) begin
                    if (MD[i] == 0)       tgt = restart ? 0 : m_ptr[i];
                    else if (sv < NL[i])  tgt = sv;
                    else                  err = 1'b1;
                end
                if (MD[i] == 0) begin
                    if (restart)    m_ptr[i] = valid ? 1 : 0;
                    else if (valid) m_ptr[i] = (m_ptr[i] + 1) % NL[i];
                end
                m_vo[i] = (tgt >= 0) ? 8'(1 << tgt) : 8'h00;
                m_fd[i] = (tgt == NL[i] - 1);
                m_er[i] = err;
                for (int k = 0; k < NL[i]; k++) begin
                    if (k == tgt) m_lane[i][k] = data_in;
`ifdef DEMUX_IDLE_FILL_EN
                    else          m_lane[i][k] = 8'hBC;
`endif
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            logic [63:0] exp_d;
            exp_d = '0;
            for (int k = 0; k < NL[i]; k++) exp_d[k*8 +: 8] = m_lane[i][k];
            chk($sformatf("validout[%0d]", i),   vo_all[i*8 +: 8],   m_vo[i]);
            chk($sformatf("dataout[%0d]", i),    do_all[i*64 +: 64], exp_d);
            chk($sformatf("frame_done[%0d]", i), fd_all[i],          m_fd[i]);
            chk($sformatf("err_sel[%0d]", i),    er_all[i],          m_er[i]);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic rs,
                       input logic [7:0] d, input logic [2:0] s);
        reset   = r;
        valid   = v;
        restart = rs;
        data_in = d;
        sel     = s;
        @(posedge clk_4f);
        n_vec++;
        model_update();
        @(negedge clk_4f);
        compare_all();
    endtask

    initial begin
        // reset state
        cyc(1, 0, 0, 8'h00, 0);
        chk("rst_validout", 64'(vo_all), 0);
        chk("rst_dataout0", do_all[63:0], 0);
        chk("rst_flags", 64'({fd_all, er_all}), 0);

        // round-robin striping, 2 lanes (instance 0)
        cyc(0, 1, 0, 8'hA1, 0);
        chk("t1_vo_a", vo_all[7:0], 8'h01);
        chk("t1_l0_a", lane_of(0, 0), 8'hA1);
        chk("t1_fd_a", fd_all[0], 0);
        cyc(0, 1, 0, 8'hB2, 0);
        chk("t1_vo_b", vo_all[7:0], 8'h02);
        chk("t1_l1_b", lane_of(0, 1), 8'hB2);
        chk("t1_fd_b", fd_all[0], 1);
        cyc(0, 1, 0, 8'hC3, 0);
        chk("t1_vo_c", vo_all[7:0], 8'h01);
        chk("t1_l0_c", lane_of(0, 0), 8'hC3);
        cyc(0, 1, 0, 8'hD4, 0);
        chk("t1_vo_d", vo_all[7:0], 8'h02);
        chk("t1_l1_d", lane_of(0, 1), 8'hD4);
        chk("t1_fd_d", fd_all[0], 1);

        // wrap with gap, 3 lanes (instance 1)
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h11, 0);
        cyc(0, 0, 0, 8'h99, 0);
        chk("t2_vo_gap", vo_all[15:8], 8'h00);
`ifndef DEMUX_IDLE_FILL_EN
        chk("t2_hold_gap", lane_of(1, 0), 8'h11);
`endif
        cyc(0, 1, 0, 8'h22, 0);
        chk("t2_vo_22", vo_all[15:8], 8'h02);
        chk("t2_fd_22", fd_all[1], 0);
        cyc(0, 1, 0, 8'h33, 0);
        chk("t2_vo_33", vo_all[15:8], 8'h04);
        chk("t2_fd_33", fd_all[1], 1);
        cyc(0, 1, 0, 8'h44, 0);
        chk("t2_vo_44", vo_all[15:8], 8'h01);
        chk("t2_l0_44", lane_of(1, 0), 8'h44);
        chk("t2_fd_44", fd_all[1], 0);

        // restart, 4 lanes (instance 2)
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h01, 0);
        cyc(0, 1, 0, 8'h02, 0);
        cyc(0, 1, 1, 8'h03, 0);
        chk("t3_vo_03", vo_all[23:16], 8'h01);
        chk("t3_l0_03", lane_of(2, 0), 8'h03);
        cyc(0, 1, 0, 8'h04, 0);
        chk("t3_vo_04", vo_all[23:16], 8'h02);
        chk("t3_l1_04", lane_of(2, 1), 8'h04);
        chk("t3_fd_04", fd_all[2], 0);

        // explicit select, 3 lanes (instance 3)
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h5A, 3'd2);
        chk("t4_vo_5a", vo_all[31:24], 8'h04);
        chk("t4_l2_5a", lane_of(3, 2), 8'h5A);
        chk("t4_fd_5a", fd_all[3], 1);
        cyc(0, 1, 0, 8'h77, 3'd3);
        chk("t4_vo_oor", vo_all[31:24], 8'h00);
        chk("t4_err_oor", er_all[3], 1);
        chk("t4_fd_oor", fd_all[3], 0);
`ifndef DEMUX_IDLE_FILL_EN
        chk("t4_hold_oor", lane_of(3, 2), 8'h5A);
`endif
        cyc(0, 0, 0, 8'h00, 3'd3);
        chk("t4_err_clr", er_all[3], 0);

        // reset mid-stream (instance 0)
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h55, 0);
        cyc(1, 1, 0, 8'hEE, 0);
        chk("t5_vo", 64'(vo_all), 0);
        chk("t5_do", do_all[63:0], 0);
        chk("t5_fd", 64'(fd_all), 0);
        cyc(0, 1, 0, 8'h66, 0);
        chk("t5_vo_next", vo_all[7:0], 8'h01);
        chk("t5_l0_next", lane_of(0, 0), 8'h66);

`ifdef DEMUX_IDLE_FILL_EN
        // idle fill (instance 0)
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h10, 0);
        chk("t6_l0_wr", lane_of(0, 0), 8'h10);
        chk("t6_l1_wr", lane_of(0, 1), 8'hBC);
        cyc(0, 0, 0, 8'h00, 0);
        chk("t6_l0_idle", lane_of(0, 0), 8'hBC);
        chk("t6_l1_idle", lane_of(0, 1), 8'hBC);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 6) == 0),
                8'($urandom),
                3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
